// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad event path: key code constants,
// decoder FSM state encoding and the one-hot sample classifier.
package keypad_pkg;

  localparam logic [3:0] KEY_0    = 4'h0;
  localparam logic [3:0] KEY_1    = 4'h1;
  localparam logic [3:0] KEY_2    = 4'h2;
  localparam logic [3:0] KEY_3    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_7    = 4'h7;
  localparam logic [3:0] KEY_8    = 4'h8;
  localparam logic [3:0] KEY_9    = 4'h9;
  localparam logic [3:0] KEY_STAR = 4'hA;
  localparam logic [3:0] KEY_HASH = 4'hB;

  // Event entry layout: {repeat, code}
  localparam int EV_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_t;

  // Returns {valid, code}. Only a single set bit is a key; zero or several
  // set bits both classify as "no key" and return all zeros.
  function automatic logic [4:0] onehot_to_code(input logic [11:0] sample);
    logic [3:0] ones;
    logic [3:0] code;
    ones = '0;
    code = KEY_0;
    for (int i = 0; i < 12; i++) begin
      if (sample[i]) begin
        ones = ones + 4'd1;
        case (i)
          0:       code = KEY_1;
          1:       code = KEY_2;
          2:       code = KEY_3;
          3:       code = KEY_4;
          4:       code = KEY_5;
          5:       code = KEY_6;
          6:       code = KEY_7;
          7:       code = KEY_8;
          8:       code = KEY_9;
          9:       code = KEY_STAR;
          10:      code = KEY_0;
          11:      code = KEY_HASH;
          default: code = KEY_0;
        endcase
      end
    end
    return (ones == 4'd1) ? {1'b1, code} : 5'b0_0000;
  endfunction

endpackage

// File: rtl/key_event_decoder_fifo.sv
// First-word-fall-through event FIFO with sticky overflow flag.
// A push into a full FIFO is only accepted when a pop happens in the same cycle.
module key_event_fifo
  import keypad_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            push,
  input  logic [EV_W-1:0] push_data,
  input  logic            ready,
  input  logic            ovf_clr,
  output logic            valid,
  output logic [EV_W-1:0] head,
  output logic [CW-1:0]   count,
  output logic            ovf
);

  logic [EV_W-1:0] mem_reg [DEPTH];
  logic [AW-1:0]   wr_ptr_reg;
  logic [AW-1:0]   rd_ptr_reg;
  logic [CW-1:0]   count_reg;
  logic [CW-1:0]   count_next;
  logic            ovf_reg;
  logic            full;
  logic            pop;
  logic            do_push;
  logic            drop;

  assign full    = (count_reg == CW'(DEPTH));
  assign valid   = (count_reg != '0);
  assign pop     = valid & ready;
  assign do_push = push & (~full | pop);
  assign drop    = push & full & ~pop;

  // Occupancy only moves when exactly one of push/pop is taken
  always_comb begin
    count_next = count_reg;
    case ({do_push, pop})
      2'b10:   count_next = count_reg + CW'(1);
      2'b01:   count_next = count_reg - CW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Entry storage; contents are don't-care until written, head is masked when empty
  always_ff @(posedge clk) begin
    if (do_push) mem_reg[wr_ptr_reg] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two; ovf_clr loses to a new drop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      ovf_reg    <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)     rd_ptr_reg <= rd_ptr_reg + AW'(1);
      count_reg <= count_next;
      ovf_reg   <= (ovf_reg & ~ovf_clr) | drop;
    end
  end

  assign head  = valid ? mem_reg[rd_ptr_reg] : '0;
  assign count = count_reg;
  assign ovf   = ovf_reg;

endmodule

// File: rtl/key_event_decoder.sv
// Keypad event decoder: classifies the scanner's one-hot sample, debounces
// press and release, generates press and auto-repeat events and queues them.
module key_event_decoder
  import keypad_pkg::*;
#(
  parameter  int DEBOUNCE_CYCLES = 16,
  parameter  int REPEAT_DELAY    = 0,
  parameter  int REPEAT_RATE     = 1000,
  parameter  int FIFO_DEPTH      = 4,
  localparam int CNT_W           = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [11:0]      key_data,
  output logic             ev_valid,
  output logic [3:0]       ev_code,
  output logic             ev_repeat,
  input  logic             ev_ready,
  output logic [CNT_W-1:0] ev_count,
  output logic             ovf,
  input  logic             ovf_clr
);

  // One counter width covers every threshold so no counter wraps inside a state
  localparam int MAX_A = (DEBOUNCE_CYCLES > REPEAT_DELAY) ? DEBOUNCE_CYCLES : REPEAT_DELAY;
  localparam int MAX_T = (MAX_A > REPEAT_RATE) ? MAX_A : REPEAT_RATE;
  localparam int TW    = $clog2(MAX_T + 1);

  localparam logic [TW:0] DEB_T   = (TW+1)'(DEBOUNCE_CYCLES);
  localparam logic [TW:0] DELAY_T = (TW+1)'(REPEAT_DELAY);
  localparam logic [TW:0] RATE_T  = (TW+1)'(REPEAT_RATE);

  key_state_t      state_reg, state_next;
  logic [3:0]      cand_reg, cand_next;
  logic [TW-1:0]   cnt_reg, cnt_next;
  logic [TW-1:0]   rcnt_reg, rcnt_next;
  logic            rate_phase_reg, rate_phase_next;

  logic [4:0]      sample_dec;
  logic            sample_valid;
  logic [3:0]      sample_code;
  logic            match;
  logic [TW:0]     cnt_inc;
  logic [TW:0]     rcnt_inc;
  logic [TW:0]     rep_thresh;
  logic            push;
  logic [EV_W-1:0] push_data;
  logic [EV_W-1:0] head;

  assign sample_dec   = onehot_to_code(key_data);
  assign sample_valid = sample_dec[4];
  assign sample_code  = sample_dec[3:0];
  assign match        = sample_valid && (sample_code == cand_reg);
  assign cnt_inc      = {1'b0, cnt_reg} + (TW+1)'(1);
  assign rcnt_inc     = {1'b0, rcnt_reg} + (TW+1)'(1);
  // First repeat waits REPEAT_DELAY, later ones REPEAT_RATE
  assign rep_thresh   = rate_phase_reg ? RATE_T : DELAY_T;

  // State and counter registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cand_reg       <= '0;
      cnt_reg        <= '0;
      rcnt_reg       <= '0;
      rate_phase_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      cand_reg       <= cand_next;
      cnt_reg        <= cnt_next;
      rcnt_reg       <= rcnt_next;
      rate_phase_reg <= rate_phase_next;
    end
  end

  // Next-state, counter updates and event generation
  always_comb begin
    state_next      = state_reg;
    cand_next       = cand_reg;
    cnt_next        = cnt_reg;
    rcnt_next       = rcnt_reg;
    rate_phase_next = rate_phase_reg;
    push            = 1'b0;
    push_data       = {1'b0, cand_reg};
    case (state_reg)
      ST_IDLE: begin
        if (sample_valid) begin
          cand_next = sample_code;
          if (DEBOUNCE_CYCLES == 1) begin
            state_next      = ST_HELD;
            push            = 1'b1;
            push_data       = {1'b0, sample_code};
            rcnt_next       = '0;
            rate_phase_next = 1'b0;
          end else begin
            state_next = ST_DEBOUNCE;
            cnt_next   = TW'(1);
          end
        end
      end
      ST_DEBOUNCE: begin
        if (match) begin
          if (cnt_inc == DEB_T) begin
            state_next      = ST_HELD;
            push            = 1'b1;
            rcnt_next       = '0;
            rate_phase_next = 1'b0;
          end else begin
            cnt_next = cnt_inc[TW-1:0];
          end
        end else begin
          state_next = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (match) begin
          if (REPEAT_DELAY > 0) begin
            if (rcnt_inc == rep_thresh) begin
              push            = 1'b1;
              push_data       = {1'b1, cand_reg};
              rcnt_next       = '0;
              rate_phase_next = 1'b1;
            end else begin
              rcnt_next = rcnt_inc[TW-1:0];
            end
          end
        end else begin
          state_next = ST_RELEASE;
          cnt_next   = TW'(1);
        end
      end
      ST_RELEASE: begin
        if (match) begin
          // Release bounce: resume holding with the repeat timer untouched
          state_next = ST_HELD;
        end else if (sample_valid) begin
          // A different key restarts the release count; no new key until clean release
          cnt_next = '0;
        end else if (cnt_inc >= DEB_T) begin
          state_next = ST_IDLE;
        end else begin
          cnt_next = cnt_inc[TW-1:0];
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  key_event_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_data),
    .ready    (ev_ready),
    .ovf_clr  (ovf_clr),
    .valid    (ev_valid),
    .head     (head),
    .count    (ev_count),
    .ovf      (ovf)
  );

  assign ev_code   = head[3:0];
  assign ev_repeat = head[4];

endmodule

// File: tb/tb_key_event_decoder.sv
// Self-checking bench for key_event_decoder: directed scenarios plus a
// randomized key-segment run checked against a timing/queue model.
`timescale 1ns/1ps
module tb_key_event_decoder;

  localparam int DC    = 4;
  localparam int RD    = 20;
  localparam int RR    = 8;
  localparam int DEPTH = 4;
  localparam int CW    = 3;
  localparam int MAXC  = 2000;
  localparam int SEGS  = 28;

  logic          clk = 1'b0;
  logic          rst;
  logic [11:0]   key_data;
  logic          ev_valid;
  logic [3:0]    ev_code;
  logic          ev_repeat;
  logic          ev_ready;
  logic [CW-1:0] ev_count;
  logic          ovf;
  logic          ovf_clr;

  int n_checks = 0;
  int n_fail   = 0;

  // Random run stimulus and expected push schedule
  logic [11:0] r_key  [MAXC];
  bit          r_push [MAXC];
  logic [4:0]  r_ev   [MAXC];
  bit          r_rdy  [MAXC];
  bit          r_clr  [MAXC];

  always #5 clk = ~clk;

  key_event_decoder #(
    .DEBOUNCE_CYCLES(DC),
    .REPEAT_DELAY   (RD),
    .REPEAT_RATE    (RR),
    .FIFO_DEPTH     (DEPTH)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .key_data (key_data),
    .ev_valid (ev_valid),
    .ev_code  (ev_code),
    .ev_repeat(ev_repeat),
    .ev_ready (ev_ready),
    .ev_count (ev_count),
    .ovf      (ovf),
    .ovf_clr  (ovf_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic hold(input logic [11:0] k, input int n);
    key_data = k;
    repeat (n) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; key_data = '0; ev_ready = 1'b0; ovf_clr = 1'b0;
    repeat (3) tick();
    @(negedge clk);
    n_checks++;
    if ({ev_valid, ev_code, ev_repeat, ev_count, ovf} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %b expected 0", {ev_valid, ev_code, ev_repeat, ev_count, ovf});
    end
    tick();
    rst = 1'b0;
    hold(12'h000, 3);
    @(negedge clk);
    n_checks++;
    if ({ev_valid, ev_count, ovf} !== 5'b0) begin
      n_fail++;
      $display("FAIL post_reset_idle: got %b expected 0", {ev_valid, ev_count, ovf});
    end
    tick();
  endtask

  task automatic test_clean_press();
    int exp_cnt;
    ev_ready = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      key_data = (i <= 30) ? 12'h010 : 12'h000;
      @(negedge clk);
      exp_cnt = (i >= 25) ? 2 : (i >= 5) ? 1 : 0;
      n_checks++;
      if (ev_count !== CW'(exp_cnt) || ev_valid !== (exp_cnt != 0)) begin
        n_fail++;
        $display("FAIL clean_press_count cycle %0d: got count=%0d valid=%b expected count=%0d", i, ev_count, ev_valid, exp_cnt);
      end
      tick();
    end
    ev_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ev_valid, ev_repeat, ev_code} !== 6'b1_0_0101) begin
      n_fail++;
      $display("FAIL clean_press_head: got v=%b r=%b c=%h expected v=1 r=0 c=5", ev_valid, ev_repeat, ev_code);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if ({ev_valid, ev_repeat, ev_code} !== 6'b1_1_0101) begin
      n_fail++;
      $display("FAIL clean_press_repeat: got v=%b r=%b c=%h expected v=1 r=1 c=5", ev_valid, ev_repeat, ev_code);
    end
    tick();
    ev_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({ev_valid, ev_repeat, ev_code, ev_count} !== 9'b0) begin
      n_fail++;
      $display("FAIL empty_outputs: got v=%b r=%b c=%h n=%0d expected all 0", ev_valid, ev_repeat, ev_code, ev_count);
    end
    tick();
  endtask

  task automatic test_bounce();
    ev_ready = 1'b0;
    hold(12'h200, 3); hold(12'h000, 1); hold(12'h200, 3); hold(12'h000, 5);
    @(negedge clk);
    n_checks++;
    if (ev_count !== 3'd0) begin
      n_fail++;
      $display("FAIL bounce_no_event: got count=%0d expected 0", ev_count);
    end
    tick();
    hold(12'h200, 4); hold(12'h000, 6);
    @(negedge clk);
    n_checks++;
    if (ev_count !== 3'd1 || {ev_repeat, ev_code} !== 5'h0A) begin
      n_fail++;
      $display("FAIL bounce_press: got count=%0d r=%b c=%h expected count=1 r=0 c=a", ev_count, ev_repeat, ev_code);
    end
    ev_ready = 1'b1;
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic test_release_bounce();
    ev_ready = 1'b0;
    hold(12'h800, 5); hold(12'h000, 2); hold(12'h800, 5); hold(12'h000, 4);
    // A press exactly DC long right after the release is only caught from IDLE
    hold(12'h004, 4); hold(12'h000, 5);
    @(negedge clk);
    n_checks++;
    if (ev_count !== 3'd2 || {ev_repeat, ev_code} !== 5'h0B) begin
      n_fail++;
      $display("FAIL release_bounce: got count=%0d r=%b c=%h expected count=2 r=0 c=b", ev_count, ev_repeat, ev_code);
    end
    ev_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if ({ev_valid, ev_repeat, ev_code} !== 6'b1_0_0011) begin
      n_fail++;
      $display("FAIL release_then_press: got v=%b r=%b c=%h expected v=1 r=0 c=3", ev_valid, ev_repeat, ev_code);
    end
    tick();
    ev_ready = 1'b0;
  endtask

  task automatic test_auto_repeat();
    int obs_cyc[$];
    logic [4:0] obs_ev[$];
    int exp_cyc[6] = '{5, 25, 33, 41, 49, 57};
    ev_ready = 1'b1;
    for (int i = 1; i <= 66; i++) begin
      key_data = (i <= 60) ? 12'h400 : 12'h000;
      @(negedge clk);
      if (ev_valid) begin
        obs_cyc.push_back(i);
        obs_ev.push_back({ev_repeat, ev_code});
      end
      tick();
    end
    ev_ready = 1'b0;
    n_checks++;
    if (obs_cyc.size() != 6) begin
      n_fail++;
      $display("FAIL repeat_event_count: got %0d expected 6", obs_cyc.size());
    end
    for (int k = 0; k < 6 && k < obs_cyc.size(); k++) begin
      n_checks++;
      if (obs_cyc[k] != exp_cyc[k] || obs_ev[k] !== {(k != 0), 4'h0}) begin
        n_fail++;
        $display("FAIL repeat_event_%0d: got cycle=%0d ev=%h expected cycle=%0d ev=%h", k, obs_cyc[k], obs_ev[k], exp_cyc[k], {(k != 0), 4'h0});
      end
    end
  endtask

  task automatic test_overflow();
    logic [11:0] keys[5] = '{12'h001, 12'h002, 12'h004, 12'h008, 12'h020};
    logic [3:0]  exp_codes[4] = '{4'h1, 4'h2, 4'h3, 4'h4};
    ev_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      hold(keys[k], 4); hold(12'h000, 4);
      if (k == 3) begin
        @(negedge clk);
        n_checks++;
        if (ev_count !== 3'd4 || ovf !== 1'b0) begin
          n_fail++;
          $display("FAIL full_no_ovf: got count=%0d ovf=%b expected count=4 ovf=0", ev_count, ovf);
        end
        tick();
      end
    end
    @(negedge clk);
    n_checks++;
    if (ev_count !== 3'd4 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL overflow_flag: got count=%0d ovf=%b expected count=4 ovf=1", ev_count, ovf);
    end
    tick();
    ev_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      n_checks++;
      if ({ev_valid, ev_repeat, ev_code} !== {2'b10, exp_codes[k]}) begin
        n_fail++;
        $display("FAIL overflow_pop_%0d: got v=%b r=%b c=%h expected v=1 r=0 c=%h", k, ev_valid, ev_repeat, ev_code, exp_codes[k]);
      end
      tick();
    end
    ev_ready = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ev_count !== 3'd0 || ovf !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_sticky: got count=%0d ovf=%b expected count=0 ovf=1", ev_count, ovf);
    end
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    @(negedge clk);
    n_checks++;
    if (ovf !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clear: got ovf=%b expected 0", ovf);
    end
    tick();
  endtask

  task automatic test_illegal_and_reset();
    ev_ready = 1'b0;
    hold(12'h011, 10); hold(12'h000, 2);
    @(negedge clk);
    n_checks++;
    if (ev_count !== 3'd0) begin
      n_fail++;
      $display("FAIL illegal_no_event: got count=%0d expected 0", ev_count);
    end
    tick();
    hold(12'h001, 4); hold(12'h000, 4); hold(12'h002, 4); hold(12'h000, 4);
    hold(12'h100, 2);
    @(negedge clk);
    n_checks++;
    if (ev_count !== 3'd2) begin
      n_fail++;
      $display("FAIL queued_before_reset: got count=%0d expected 2", ev_count);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ev_valid, ev_code, ev_repeat, ev_count, ovf} !== 10'b0) begin
      n_fail++;
      $display("FAIL reset_mid_debounce: got %b expected 0", {ev_valid, ev_code, ev_repeat, ev_count, ovf});
    end
    tick();
    rst = 1'b0;
    // Three more samples of the same key must not complete the discarded debounce
    hold(12'h100, 3); hold(12'h000, 5);
    @(negedge clk);
    n_checks++;
    if (ev_count !== 3'd0 || ev_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_discards_debounce: got count=%0d valid=%b expected 0", ev_count, ev_valid);
    end
    tick();
  endtask

  task automatic test_random();
    int         code_of[12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 0, 11};
    int         n;
    logic [4:0] q[$];
    bit         m_ovf;
    bit         pop;
    bit         drop;
    logic [9:0] exp_v;
    logic [9:0] got_v;
    logic [11:0] one;
    one = 12'h001;
    n = 0;
    for (int c = 0; c < MAXC; c++) begin
      r_key[c] = '0; r_push[c] = 1'b0; r_ev[c] = '0;
      r_rdy[c] = ($urandom_range(0, 2) == 0);
      r_clr[c] = ($urandom_range(0, 15) == 0);
    end
    for (int s = 0; s < SEGS; s++) begin
      int b0, b1, len, gap, p;
      bit legal;
      logic [11:0] k;
      b0    = $urandom_range(0, 11);
      b1    = (b0 + $urandom_range(1, 11)) % 12;
      legal = ($urandom_range(0, 5) != 0);
      k     = legal ? (one << b0) : ((one << b0) | (one << b1));
      len   = $urandom_range(1, 50);
      gap   = $urandom_range(DC, DC + 5);
      for (int j = 0; j < len; j++) r_key[n + j] = k;
      if (legal && len >= DC) begin
        p = n + DC - 1;
        r_push[p] = 1'b1;
        r_ev[p]   = {1'b0, 4'(code_of[b0])};
        for (int t = p + RD; t <= n + len - 1; t += RR) begin
          r_push[t] = 1'b1;
          r_ev[t]   = {1'b1, 4'(code_of[b0])};
        end
      end
      n += len + gap;
    end
    m_ovf = 1'b0;
    for (int c = 0; c < n; c++) begin
      key_data = r_key[c];
      ev_ready = r_rdy[c];
      ovf_clr  = r_clr[c];
      @(negedge clk);
      exp_v = {(q.size() != 0), (q.size() != 0) ? q[0] : 5'b0, 3'(q.size()), m_ovf};
      got_v = {ev_valid, ev_repeat, ev_code, ev_count, ovf};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: got {v,r,c,n,ovf}=%b expected %b", c, got_v, exp_v);
      end
      @(posedge clk);
      pop  = (q.size() != 0) && r_rdy[c];
      drop = 1'b0;
      if (pop) void'(q.pop_front());
      if (r_push[c]) begin
        if (q.size() < DEPTH) q.push_back(r_ev[c]);
        else drop = 1'b1;
      end
      m_ovf = (m_ovf && !r_clr[c]) || drop;
      #1;
    end
    ev_ready = 1'b0;
    ovf_clr  = 1'b0;
    key_data = '0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_bounce();
    test_auto_repeat();
    test_overflow();
    test_illegal_and_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
